game_tick_scheduler: RTL and testbench

Central timing controller for the game core. It replaces the free-running clock dividers with single-cycle enable strobes on the system clock. It sequences a move tick whose period shortens with difficulty level, and a one-second tick that drives a countdown game timer. It owns the run/pause/stop/game-over sequencing, so gameplay logic stays on one clock domain.

---
 rtl/game_timing_pkg.sv | 16 +
 rtl/tick_counter.sv | 45 ++++
 rtl/game_tick_scheduler.sv | 134 +++++++++++++
 tb/tb_game_tick_scheduler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_timing_pkg.sv
// Shared timing definitions for the game tick scheduler.
//   state_t  : scheduler FSM encoding (IDLE/RUN/PAUSE/DONE)
//   LEVEL_W  : width of the difficulty level; sized for levels 0..3
package game_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // clog2(MAX_LEVEL+1) for the default MAX_LEVEL of 3.
  localparam int LEVEL_W = 2;

endpackage

// File: rtl/tick_counter.sv
// Wrapping terminal-count divider that produces a one-cycle enable strobe.
//   clk    : system clock, rising edge
//   rst    : asynchronous active-high reset
//   en     : count this cycle
//   clr    : clear count to 0 and load period (wins over en)
//   period : terminal count; sampled only on clr or on a wrap
//   tick   : registered strobe, high in the cycle after a wrap
//   wrap   : combinational, high in the cycle whose edge performs a wrap
//            (lets the parent update state on the same edge as the strobe)
module tick_counter #(
  parameter int DIV_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] period,
  output logic             tick,
  output logic             wrap
);

  logic [DIV_W-1:0] count;
  // Period in force for the count in progress; a new period input
  // only takes effect at the next wrap, never mid-count.
  logic [DIV_W-1:0] prd;

  assign wrap = en && !clr && (count == prd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      prd   <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= wrap;
      if (clr || wrap) begin
        count <= '0;
        prd   <= period;
      end else if (en) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_tick_scheduler.sv
// Central game timing controller: run/pause/stop/game-over sequencing,
// a level-dependent move tick and a one-second tick that counts down
// the game timer. All strobes are single-cycle enables on clk.
//   clk, rst  : system clock / asynchronous active-high reset
//   start     : begin from IDLE/DONE, resume from PAUSE
//   pause     : RUN -> PAUSE
//   stop      : any state -> IDLE (clears level, reloads timer)
//   level_up  : raise level by one, saturating at MAX_LEVEL
//   move_tick : one-cycle strobe per move period
//   sec_tick  : one-cycle strobe per second
//   time_left : seconds remaining
//   level     : current difficulty level
//   running   : high in RUN
//   game_over : high in DONE
// Control pulses are single-cycle, sampled on the rising edge. When they
// coincide, stop beats pause beats start; pause has no effect outside RUN
// but still blocks a simultaneous start. level_up is independent.
// Requires BASE_DIV > MAX_LEVEL*STEP_DIV so the move period stays positive.
module game_tick_scheduler
  import game_timing_pkg::*;
#(
  parameter int BASE_DIV  = 833332,
  parameter int STEP_DIV  = 100000,
  parameter int MAX_LEVEL = 3,
  parameter int SEC_DIV   = 99999999,
  parameter int GAME_SECS = 60,
  parameter int DIV_W     = 27
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic               stop,
  input  logic               level_up,
  output logic               move_tick,
  output logic               sec_tick,
  output logic [7:0]         time_left,
  output logic [LEVEL_W-1:0] level,
  output logic               running,
  output logic               game_over
);

  state_t           state;
  state_t           state_nxt;
  logic             load;       // entering RUN from IDLE/DONE: full reload
  logic             clr;        // clear both counters
  logic             en;         // counters advance only in RUN
  logic             move_wrap;
  logic             sec_wrap;
  logic             final_sec;  // second wrap that ends the game
  logic [DIV_W-1:0] div_cur;
  logic [DIV_W-1:0] sec_div;

  assign div_cur   = DIV_W'(BASE_DIV) - DIV_W'(level) * DIV_W'(STEP_DIV);
  assign sec_div   = DIV_W'(SEC_DIV);
  assign final_sec = sec_wrap && (time_left == 8'd1);
  assign load      = ((state == ST_IDLE) || (state == ST_DONE)) &&
                     (state_nxt == ST_RUN);
  assign clr       = stop || load;
  assign en        = (state == ST_RUN);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. Game over outranks pause so a pause landing on the
  // final second cannot leave a zero timer in PAUSE; stop outranks both.
  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (!pause && start) state_nxt = ST_RUN;
        ST_RUN: begin
          if (final_sec)  state_nxt = ST_DONE;
          else if (pause) state_nxt = ST_PAUSE;
        end
        ST_PAUSE: if (!pause && start) state_nxt = ST_RUN;
        ST_DONE:  if (!pause && start) state_nxt = ST_RUN;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output decode straight from the state register.
  always_comb begin
    running   = (state == ST_RUN);
    game_over = (state == ST_DONE);
  end

  // Countdown timer: reloads on any counter clear, decrements per second.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           time_left <= 8'(GAME_SECS);
    else if (clr)      time_left <= 8'(GAME_SECS);
    else if (sec_wrap) time_left <= time_left - 8'd1;
  end

  // Difficulty level: accepted in any state, saturating, cleared by stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
    end else if (stop) begin
      level <= '0;
    end else if (level_up && (level != LEVEL_W'(MAX_LEVEL))) begin
      level <= level + 1'b1;
    end
  end

  // The move counter latches div_cur only on clr or wrap, so a level
  // change shortens the period starting with the next move.
  tick_counter #(.DIV_W(DIV_W)) u_move (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .clr    (clr),
    .period (div_cur),
    .tick   (move_tick),
    .wrap   (move_wrap)
  );

  tick_counter #(.DIV_W(DIV_W)) u_second (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .clr    (clr),
    .period (sec_div),
    .tick   (sec_tick),
    .wrap   (sec_wrap)
  );

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Bench for game_tick_scheduler with BASE_DIV=9, STEP_DIV=2, MAX_LEVEL=3,
// SEC_DIV=19, GAME_SECS=3. Cycle c of a scenario is the cycle that begins
// with the c-th rising edge after reset release; a pulse "at cycle c" is
// the one sampled by that edge.
module tb_game_tick_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       stop = 1'b0;
  logic       level_up = 1'b0;
  logic       move_tick;
  logic       sec_tick;
  logic [7:0] time_left;
  logic [1:0] level;
  logic       running;
  logic       game_over;

  game_tick_scheduler #(
    .BASE_DIV  (9),
    .STEP_DIV  (2),
    .MAX_LEVEL (3),
    .SEC_DIV   (19),
    .GAME_SECS (3),
    .DIV_W     (27)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .stop      (stop),
    .level_up  (level_up),
    .move_tick (move_tick),
    .sec_tick  (sec_tick),
    .time_left (time_left),
    .level     (level),
    .running   (running),
    .game_over (game_over)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- vector tables and scoreboard ----------------
  typedef struct {
    int         cyc;
    logic       start;
    logic       pause;
    logic       stop;
    logic       level_up;
    logic       chk;      // compare status fields in this cycle
    logic [7:0] tl;
    logic [1:0] lv;
    logic       run;
    logic       go;
  } vec_t;

  vec_t vecs[$];
  int   move_at[$];
  int   sec_at[$];
  // {chk, move, sec, running, game_over, time_left[7:0], level[1:0]}
  logic [14:0] exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic vec_t mk(input int cyc, input logic st, input logic pa,
                              input logic sp, input logic lu, input logic chk,
                              input logic [7:0] tl, input logic [1:0] lv,
                              input logic run, input logic go);
    vec_t v;
    v.cyc = cyc; v.start = st; v.pause = pa; v.stop = sp; v.level_up = lu;
    v.chk = chk; v.tl = tl; v.lv = lv; v.run = run; v.go = go;
    return v;
  endfunction

  task automatic clear_tables();
    vecs.delete();
    move_at.delete();
    sec_at.delete();
  endtask

  task automatic check(input string name, input int c,
                       input logic [13:0] act, input logic [13:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  task automatic check_cycle(input string scen, input int c);
    logic [14:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s cycle %0d: scoreboard empty", scen, c);
    end else begin
      e = exp_q.pop_front();
      check({scen, " strobes"}, c, {12'd0, move_tick, sec_tick},
            {12'd0, e[13], e[12]});
      if (e[14])
        check({scen, " status"}, c,
              {2'b00, running, game_over, time_left, level},
              {2'b00, e[11:0]});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0; pause = 1'b0; stop = 1'b0; level_up = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #1;
  endtask

  task automatic run(input string scen, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      logic [14:0] e;
      logic        mv;
      logic        sc;
      start = 1'b0; pause = 1'b0; stop = 1'b0; level_up = 1'b0;
      e = '0;
      foreach (vecs[i]) begin
        if (vecs[i].cyc == c) begin
          start    = start    | vecs[i].start;
          pause    = pause    | vecs[i].pause;
          stop     = stop     | vecs[i].stop;
          level_up = level_up | vecs[i].level_up;
          if (vecs[i].chk)
            e = {1'b1, 2'b00, vecs[i].run, vecs[i].go, vecs[i].tl, vecs[i].lv};
        end
      end
      mv = 1'b0;
      sc = 1'b0;
      foreach (move_at[i]) if (move_at[i] == c) mv = 1'b1;
      foreach (sec_at[i])  if (sec_at[i] == c)  sc = 1'b1;
      e[13] = mv;
      e[12] = sc;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check_cycle(scen, c);
    end
    start = 1'b0; pause = 1'b0; stop = 1'b0; level_up = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Async reset takes effect before any clock edge.
    #1 rst = 1'b1;
    #3;
    check("reset_state", 0, {move_tick, sec_tick, running, game_over, time_left, level},
          {1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 2'd0});

    // Full game: ticks, countdown, game over with coincident move tick,
    // silence in DONE, then restart with a full reload.
    do_reset();
    clear_tables();
    vecs.push_back(mk(0,   1,0,0,0, 1, 8'd3, 2'd0, 1, 0));
    vecs.push_back(mk(19,  0,0,0,0, 1, 8'd3, 2'd0, 1, 0));
    vecs.push_back(mk(20,  0,0,0,0, 1, 8'd2, 2'd0, 1, 0));
    vecs.push_back(mk(39,  0,0,0,0, 1, 8'd2, 2'd0, 1, 0));
    vecs.push_back(mk(40,  0,0,0,0, 1, 8'd1, 2'd0, 1, 0));
    vecs.push_back(mk(59,  0,0,0,0, 1, 8'd1, 2'd0, 1, 0));
    vecs.push_back(mk(60,  0,0,0,0, 1, 8'd0, 2'd0, 0, 1));
    vecs.push_back(mk(110, 0,0,0,0, 1, 8'd0, 2'd0, 0, 1));
    vecs.push_back(mk(111, 1,0,0,0, 1, 8'd3, 2'd0, 1, 0));
    move_at = '{10, 20, 30, 40, 50, 60, 121};
    sec_at  = '{20, 40, 60};
    run("game", 126);

    // Level changes take effect at the next wrap; saturation at 3.
    do_reset();
    clear_tables();
    vecs.push_back(mk(0,  1,0,0,0, 0, 8'd0, 2'd0, 0, 0));
    vecs.push_back(mk(5,  0,0,0,1, 1, 8'd3, 2'd1, 1, 0));
    vecs.push_back(mk(27, 0,0,0,1, 0, 8'd0, 2'd0, 0, 0));
    vecs.push_back(mk(28, 0,0,0,1, 1, 8'd2, 2'd3, 1, 0));
    vecs.push_back(mk(29, 0,0,0,1, 0, 8'd0, 2'd0, 0, 0));
    vecs.push_back(mk(30, 0,0,0,1, 0, 8'd0, 2'd0, 0, 0));
    vecs.push_back(mk(31, 0,0,0,1, 1, 8'd2, 2'd3, 1, 0));
    vecs.push_back(mk(40, 0,0,0,0, 1, 8'd1, 2'd3, 1, 0));
    move_at = '{10, 18, 26, 34, 38, 42};
    sec_at  = '{20, 40};
    run("level", 45);

    // Pause holds counters and timer; resume continues from held counts.
    do_reset();
    clear_tables();
    vecs.push_back(mk(0,  1,0,0,0, 0, 8'd0, 2'd0, 0, 0));
    vecs.push_back(mk(7,  0,1,0,0, 1, 8'd3, 2'd0, 0, 0));
    vecs.push_back(mk(13, 0,0,0,0, 1, 8'd3, 2'd0, 0, 0));
    vecs.push_back(mk(14, 1,0,0,0, 1, 8'd3, 2'd0, 1, 0));
    vecs.push_back(mk(27, 0,0,0,0, 1, 8'd2, 2'd0, 1, 0));
    move_at = '{17, 27};
    sec_at  = '{27};
    run("pause", 31);

    // Stop clears level and reloads; then async reset mid-run on a tick.
    do_reset();
    clear_tables();
    vecs.push_back(mk(0,  1,0,0,0, 0, 8'd0, 2'd0, 0, 0));
    vecs.push_back(mk(3,  0,0,0,1, 1, 8'd3, 2'd1, 1, 0));
    vecs.push_back(mk(4,  0,0,0,1, 1, 8'd3, 2'd2, 1, 0));
    vecs.push_back(mk(15, 0,0,1,0, 1, 8'd3, 2'd0, 0, 0));
    vecs.push_back(mk(25, 0,0,0,0, 1, 8'd3, 2'd0, 0, 0));
    vecs.push_back(mk(30, 1,0,0,0, 0, 8'd0, 2'd0, 0, 0));
    vecs.push_back(mk(33, 0,0,0,1, 0, 8'd0, 2'd0, 0, 0));
    vecs.push_back(mk(39, 0,0,0,0, 1, 8'd3, 2'd1, 1, 0));
    move_at = '{10, 40};
    sec_at.delete();
    run("stop", 41);
    #2 rst = 1'b1;
    #1;
    check("async_reset", 40, {move_tick, sec_tick, running, game_over, time_left, level},
          {1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 2'd0});

    // Coincident pulses: start+stop in IDLE, pause+start on a move wrap.
    do_reset();
    clear_tables();
    vecs.push_back(mk(0,  1,0,1,0, 1, 8'd3, 2'd0, 0, 0));
    vecs.push_back(mk(12, 0,0,0,0, 1, 8'd3, 2'd0, 0, 0));
    vecs.push_back(mk(13, 1,0,0,0, 1, 8'd3, 2'd0, 1, 0));
    vecs.push_back(mk(22, 0,0,0,0, 1, 8'd3, 2'd0, 1, 0));
    vecs.push_back(mk(23, 1,1,0,0, 1, 8'd3, 2'd0, 0, 0));
    vecs.push_back(mk(30, 1,0,0,0, 1, 8'd3, 2'd0, 1, 0));
    vecs.push_back(mk(40, 0,0,0,0, 1, 8'd2, 2'd0, 1, 0));
    move_at = '{23, 40};
    sec_at  = '{40};
    run("coincide", 42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
